vpu_lane_issue_ctrl: RTL
========================

// Module: vpu_lane_issue_ctrl
// PURPOSE
//  Initiator side of the VPU lane execution interface. Accepts one op request
//  (valid/ready), drives start_i/op_func/operands into a VPU lane, waits for
//  the lane's done, captures dout and returns it on a valid/ready response port.
//  One op in flight per lane; a per-op timeout guards against a lane that never completes.
// PARAMETERS
//  OPERAND_WIDTH    32  width of each operand and of the result
//  SRC_OPERAND_CNT  3   operands per request
//  OP_WIDTH         12  one-hot op_func vector width (one bit per FP function)
//  TIMEOUT_CYCLES   64  max cycles in WAIT before forced completion (>=2)
// PORTS
//  clk                   in   1                   clock
//  rst_n                 in   1                   async active-low reset
//  req_valid_i           in   1                   request valid
//  req_ready_o           out  1                   request ready (1 only in IDLE)
//  req_op_i              in   OP_WIDTH            one-hot op select
//  req_operand_i         in   SRC_CNT*OP_W        operands, operand k at [k*W +: W]
//  req_operand_valid_i   in   SRC_OPERAND_CNT     per-operand valid
//  lane_start_o          out  1                   single-cycle start pulse to lane
//  lane_op_o             out  OP_WIDTH            op_func to lane
//  lane_operand_o        out  SRC_CNT*OP_W        operands to lane
//  lane_operand_valid_o  out  SRC_OPERAND_CNT     operand valids to lane
//  lane_dout_i           in   OPERAND_WIDTH       lane result
//  lane_done_i           in   1                   lane done
//  rsp_valid_o           out  1                   response valid
//  rsp_ready_i           in   1                   response ready
//  rsp_data_o            out  OPERAND_WIDTH       captured result (0 on timeout/illegal op)
//  rsp_timeout_o         out  1                   1 = timeout or illegal op, data invalid
//  busy_o                out  1                   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all registers 0, every output 0 during reset;
//   req_ready_o=1 from the first cycle after deassert. Reset mid-op abandons it; no response.
//  States IDLE, ISSUE, WAIT, RESP.
//  IDLE: req_ready_o=1. On req_valid_i: capture op/operands/valids into registers.
//   If req_op_i==0 -> RESP with rsp_data=0, rsp_timeout=1 (no lane_start). Else -> ISSUE.
//  ISSUE: lane_start_o=1 for exactly this cycle; timeout counter cleared -> WAIT.
//  WAIT: lane_done_i=1 -> rsp_data<=lane_dout_i, rsp_timeout<=0, -> RESP.
//   Else counter++; when counter==TIMEOUT_CYCLES-1 and no done -> rsp_data<=0,
//   rsp_timeout<=1, -> RESP. Done on that same cycle wins (normal completion).
//   Counter width $clog2(TIMEOUT_CYCLES); it never wraps.
//  RESP: rsp_valid_o=1; rsp_data_o/rsp_timeout_o held stable until rsp_ready_i;
//   on rsp_valid_o&rsp_ready_i -> IDLE. No new request accepted until then.
//  lane_op_o = captured op in ISSUE and WAIT, 0 in IDLE/RESP (lane mux idles to 0).
//  lane_operand_o / lane_operand_valid_o = captured registers, held stable across op.
//  lane_done_i ignored outside WAIT (late/stray done after timeout is dropped).
//  Latency: accept at T -> start at T+1 -> earliest response at T+3 (done at T+2).
//  Throughput: 1 op per (lane latency + 3) cycles with rsp_ready_i held 1.
//  rsp_valid_o, lane_start_o, rsp_data_o, rsp_timeout_o are registered-state outputs.
// TESTING
//  ADD2 op, operands 0x3F800000/0x40000000, lane model done 3 cycles after start with
//   0x40400000 -> one lane_start pulse at T+1, rsp_valid at T+5, data 0x40400000, timeout 0.
//  Same op with rsp_ready_i low 5 cycles -> rsp_data stable, req_ready_o=0, second request
//   held off; accepted in the cycle after the rsp handshake.
//  TIMEOUT_CYCLES=8, lane never done -> rsp after 8 WAIT cycles, data 0, timeout 1;
//   later lane_done_i pulse produces no response.
//  TIMEOUT_CYCLES=8, done asserted on 8th WAIT cycle with 0x12345678 -> data 0x12345678, timeout 0.
//  req_op_i=0 -> no lane_start_o, rsp_valid next cycle with timeout 1, data 0.
//  rst_n low during WAIT -> all outputs 0 immediately; after release req_ready_o=1 and a
//   fresh MUL request (2.0*3.0 -> 0x40C00000) completes normally.

Source files
------------

// File: rtl/vpu_lane_issue_ctrl.sv
// Initiator for one VPU lane: accepts an op, pulses start into the lane, waits for done
// (or a timeout), and returns the captured result on a valid/ready response port.
module vpu_lane_issue_ctrl #(
    parameter int OPERAND_WIDTH   = 32,
    parameter int SRC_OPERAND_CNT = 3,
    parameter int OP_WIDTH        = 12,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       req_valid_i,
    output logic                                       req_ready_o,
    input  logic [OP_WIDTH-1:0]                        req_op_i,
    input  logic [SRC_OPERAND_CNT*OPERAND_WIDTH-1:0]   req_operand_i,
    input  logic [SRC_OPERAND_CNT-1:0]                 req_operand_valid_i,
    output logic                                       lane_start_o,
    output logic [OP_WIDTH-1:0]                        lane_op_o,
    output logic [SRC_OPERAND_CNT*OPERAND_WIDTH-1:0]   lane_operand_o,
    output logic [SRC_OPERAND_CNT-1:0]                 lane_operand_valid_o,
    input  logic [OPERAND_WIDTH-1:0]                   lane_dout_i,
    input  logic                                       lane_done_i,
    output logic                                       rsp_valid_o,
    input  logic                                       rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]                   rsp_data_o,
    output logic                                       rsp_timeout_o,
    output logic                                       busy_o
);

    localparam int OPS_W = SRC_OPERAND_CNT * OPERAND_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [OP_WIDTH-1:0]          lane_op_q, lane_op_d;
    logic [OPS_W-1:0]             operand_q, operand_d;
    logic [SRC_OPERAND_CNT-1:0]   operand_valid_q, operand_valid_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [OPERAND_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                         rsp_timeout_q, rsp_timeout_d;

    // Next-state and datapath capture for the issue sequencer.
    always_comb begin
        state_d         = state_q;
        lane_op_d       = lane_op_q;
        operand_d       = operand_q;
        operand_valid_d = operand_valid_q;
        cnt_d           = cnt_q;
        rsp_data_d      = rsp_data_q;
        rsp_timeout_d   = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    // An all-zero op is captured as-is, so the lane op bus stays idle for it.
                    lane_op_d       = req_op_i;
                    operand_d       = req_operand_i;
                    operand_valid_d = req_operand_valid_i;
                    rsp_data_d      = {OPERAND_WIDTH{1'b0}};
                    if (req_op_i == {OP_WIDTH{1'b0}}) begin
                        rsp_timeout_d = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        rsp_timeout_d = 1'b0;
                        state_d       = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over expiry on the final wait cycle.
                if (lane_done_i) begin
                    rsp_data_d    = lane_dout_i;
                    rsp_timeout_d = 1'b0;
                    lane_op_d     = {OP_WIDTH{1'b0}};
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = {OPERAND_WIDTH{1'b0}};
                    rsp_timeout_d = 1'b1;
                    lane_op_d     = {OP_WIDTH{1'b0}};
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            lane_op_q       <= {OP_WIDTH{1'b0}};
            operand_q       <= {OPS_W{1'b0}};
            operand_valid_q <= {SRC_OPERAND_CNT{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
            rsp_data_q      <= {OPERAND_WIDTH{1'b0}};
            rsp_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            lane_op_q       <= lane_op_d;
            operand_q       <= operand_d;
            operand_valid_q <= operand_valid_d;
            cnt_q           <= cnt_d;
            rsp_data_q      <= rsp_data_d;
            rsp_timeout_q   <= rsp_timeout_d;
        end
    end

    // Ready is qualified by rst_n so every output reads 0 while reset is held.
    assign req_ready_o          = rst_n & (state_q == S_IDLE);
    assign busy_o               = (state_q != S_IDLE);
    assign lane_start_o         = (state_q == S_ISSUE);
    assign rsp_valid_o          = (state_q == S_RESP);
    assign lane_op_o            = lane_op_q;
    assign lane_operand_o       = operand_q;
    assign lane_operand_valid_o = operand_valid_q;
    assign rsp_data_o           = rsp_data_q;
    assign rsp_timeout_o        = rsp_timeout_q;

endmodule
